// File: rtl/mr_round_sched.sv
// mr_round_sched: Miller-Rabin round scheduler for W-bit candidates.
// Rejects trivial inputs, factors n-1 = d*2^s one bit per cycle, then walks a
// fixed witness set, sending every a^d mod n and x^2 mod n to a shared
// external modexp engine (one outstanding request at a time).
// Build option: define MR_FAST_WITNESS_EN to use the 7-base witness set
// {2, 325, 9375, 28178, 450775, 9780504, 1795265022}; otherwise the 12 prime
// bases 2..37 are used. Both are deterministic for every 64-bit candidate.
module mr_round_sched #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] n,
  output logic         busy,
  output logic         done,
  output logic         is_prime,
  output logic         me_req,
  input  logic         me_rdy,
  output logic [W-1:0] me_base,
  output logic [W-1:0] me_exp,
  output logic [W-1:0] me_mod,
  input  logic         me_vld,
  input  logic [W-1:0] me_res
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    TRIV     = 4'd1,
    DECOMP   = 4'd2,
    ISSUE_X  = 4'd3,
    WAIT_X   = 4'd4,
    CHECK    = 4'd5,
    ISSUE_SQ = 4'd6,
    WAIT_SQ  = 4'd7,
    DONE     = 4'd8
  } state_t;

`ifdef MR_FAST_WITNESS_EN
  localparam logic [3:0] LAST_K = 4'd6;
`else
  localparam logic [3:0] LAST_K = 4'd11;
`endif

  localparam logic [W-1:0] ZERO  = {W{1'b0}};
  localparam logic [W-1:0] ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] TWO   = {{(W-2){1'b0}}, 2'd2};
  localparam logic [W-1:0] THREE = {{(W-2){1'b0}}, 2'd3};

  // Witness base for index idx; all bases fit in 31 bits.
  function automatic logic [W-1:0] witness(input logic [3:0] idx);
    logic [31:0] b;
    case (idx)
`ifdef MR_FAST_WITNESS_EN
      4'd0:    b = 32'd2;
      4'd1:    b = 32'd325;
      4'd2:    b = 32'd9375;
      4'd3:    b = 32'd28178;
      4'd4:    b = 32'd450775;
      4'd5:    b = 32'd9780504;
      4'd6:    b = 32'd1795265022;
      default: b = 32'd0;
`else
      4'd0:    b = 32'd2;
      4'd1:    b = 32'd3;
      4'd2:    b = 32'd5;
      4'd3:    b = 32'd7;
      4'd4:    b = 32'd11;
      4'd5:    b = 32'd13;
      4'd6:    b = 32'd17;
      4'd7:    b = 32'd19;
      4'd8:    b = 32'd23;
      4'd9:    b = 32'd29;
      4'd10:   b = 32'd31;
      4'd11:   b = 32'd37;
      default: b = 32'd0;
`endif
    endcase
    return {{(W-32){1'b0}}, b};
  endfunction

  state_t       state;
  logic [W-1:0] n_q;
  logic [W-1:0] d;
  logic [5:0]   s;
  logic [5:0]   r;
  logic [3:0]   k;
  logic [W-1:0] x;

  logic [W-1:0] n_m1;
  logic         x_pass;
  logic         sq_pass;

  assign n_m1    = n_q - ONE;
  // x == 0 covers a base that is a multiple of n (only possible for n <= base).
  assign x_pass  = (x == ZERO) || (x == ONE) || (x == n_m1);
  assign sq_pass = (me_res == n_m1);

  // Scheduler FSM: state, working registers and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      n_q      <= ZERO;
      d        <= ZERO;
      s        <= 6'd0;
      r        <= 6'd0;
      k        <= 4'd0;
      x        <= ZERO;
      busy     <= 1'b0;
      done     <= 1'b0;
      is_prime <= 1'b0;
      me_req   <= 1'b0;
      me_base  <= ZERO;
      me_exp   <= ZERO;
      me_mod   <= ZERO;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_q      <= n;
            is_prime <= 1'b0;
            busy     <= 1'b1;
            state    <= TRIV;
          end
        end

        TRIV: begin
          if (n_q < TWO) begin
            is_prime <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else if ((n_q == TWO) || (n_q == THREE)) begin
            is_prime <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else if (!n_q[0]) begin
            is_prime <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            d     <= n_m1;
            s     <= 6'd0;
            state <= DECOMP;
          end
        end

        // d is even on entry (n odd). Look one bit ahead so the state lasts
        // exactly s cycles and the first request is issued on exit.
        DECOMP: begin
          d <= d >> 1;
          s <= s + 6'd1;
          if (d[1]) begin
            k       <= 4'd0;
            r       <= 6'd0;
            me_req  <= 1'b1;
            me_base <= witness(4'd0);
            me_exp  <= d >> 1;
            me_mod  <= n_q;
            state   <= ISSUE_X;
          end
        end

        ISSUE_X: begin
          if (me_rdy) begin
            me_req <= 1'b0;
            state  <= WAIT_X;
          end
        end

        WAIT_X: begin
          if (me_vld) begin
            x     <= me_res;
            state <= CHECK;
          end
        end

        CHECK: begin
          if (x_pass) begin
            if (k == LAST_K) begin
              is_prime <= 1'b1;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= DONE;
            end else begin
              k       <= k + 4'd1;
              r       <= 6'd0;
              me_req  <= 1'b1;
              me_base <= witness(k + 4'd1);
              me_exp  <= d;
              me_mod  <= n_q;
              state   <= ISSUE_X;
            end
          end else if (r == (s - 6'd1)) begin
            is_prime <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            me_req  <= 1'b1;
            me_base <= x;
            me_exp  <= TWO;
            me_mod  <= n_q;
            state   <= ISSUE_SQ;
          end
        end

        ISSUE_SQ: begin
          if (me_rdy) begin
            me_req <= 1'b0;
            state  <= WAIT_SQ;
          end
        end

        // A square of 1 is 1 again, so x==1 can only appear here as a
        // nontrivial root of unity: composite.
        WAIT_SQ: begin
          if (me_vld) begin
            x <= me_res;
            r <= r + 6'd1;
            if (sq_pass) begin
              if (k == LAST_K) begin
                is_prime <= 1'b1;
                done     <= 1'b1;
                busy     <= 1'b0;
                state    <= DONE;
              end else begin
                k       <= k + 4'd1;
                r       <= 6'd0;
                me_req  <= 1'b1;
                me_base <= witness(k + 4'd1);
                me_exp  <= d;
                me_mod  <= n_q;
                state   <= ISSUE_X;
              end
            end else if (me_res == ONE) begin
              is_prime <= 1'b0;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= DONE;
            end else begin
              state <= CHECK;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          me_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mr_round_sched.sv
// Self-checking bench for mr_round_sched: behavioural modexp engine with random
// latency, scoreboard of expected verdicts popped on each done pulse.
`timescale 1ns/1ps
module tb_mr_round_sched;
  localparam int W = 64;
`ifdef MR_FAST_WITNESS_EN
  localparam int NB = 7;
`else
  localparam int NB = 12;
`endif
  localparam logic [63:0] BIG_P = 64'd18446744073709551557;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] n;
  logic         busy, done, is_prime, me_req, me_rdy, me_vld;
  logic [W-1:0] me_base, me_exp, me_mod, me_res;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int req_rise = -1;
  int xcnt = 0;
  logic [63:0] first_x_exp = 64'd0;
  logic [63:0] cur_n = 64'd0;
  logic [63:0] exp_d = 64'd0;
  bit sb_p[$];
  int sb_c[$];

  // engine control
  bit          pend = 1'b0;
  int          pcnt = 0;
  logic [63:0] pres = 64'd0;
  bit          eng_hold = 1'b0;
  bit          inject = 1'b0;
  logic [63:0] inj_val = 64'd0;
  int          stall_left = 0;
  bit          stall_on = 1'b0;

  mr_round_sched #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n),
    .busy(busy), .done(done), .is_prime(is_prime),
    .me_req(me_req), .me_rdy(me_rdy),
    .me_base(me_base), .me_exp(me_exp), .me_mod(me_mod),
    .me_vld(me_vld), .me_res(me_res)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] tb_base(input int i);
    case (i)
`ifdef MR_FAST_WITNESS_EN
      0: return 64'd2;
      1: return 64'd325;
      2: return 64'd9375;
      3: return 64'd28178;
      4: return 64'd450775;
      5: return 64'd9780504;
      6: return 64'd1795265022;
`else
      0: return 64'd2;   1: return 64'd3;   2: return 64'd5;   3: return 64'd7;
      4: return 64'd11;  5: return 64'd13;  6: return 64'd17;  7: return 64'd19;
      8: return 64'd23;  9: return 64'd29;  10: return 64'd31; 11: return 64'd37;
`endif
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] modexp(input logic [63:0] b, input logic [63:0] e, input logic [63:0] m);
    logic [127:0] acc, bb, mm;
    logic [63:0]  ee;
    mm  = {64'd0, m};
    acc = 128'd1 % mm;
    bb  = {64'd0, b} % mm;
    ee  = e;
    while (ee != 64'd0) begin
      if (ee[0]) acc = (acc * bb) % mm;
      bb = (bb * bb) % mm;
      ee = ee >> 1;
    end
    return acc[63:0];
  endfunction

  // Modexp engine model: accepts one request, answers 1..4 cycles later.
  initial begin
    me_rdy = 1'b0;
    me_vld = 1'b0;
    me_res = 64'd0;
    forever begin
      @(posedge clk); #1;
      me_vld = 1'b0;
      me_rdy = 1'b0;
      if (inject) begin
        me_vld = 1'b1;
        me_res = inj_val;
        inject = 1'b0;
      end
      if (!rst) begin
        pend = 1'b0;
        stall_on = 1'b0;
      end else if (pend) begin
        if (pcnt == 0) begin
          me_vld = 1'b1;
          me_res = pres;
          pend   = 1'b0;
        end else begin
          pcnt--;
        end
      end else if (stall_left > 0 && (stall_on || me_req)) begin
        stall_on = 1'b1;
        check_eq("stall_req", {63'd0, me_req}, 64'd1);
        check_eq("stall_base", me_base, tb_base(xcnt));
        check_eq("stall_exp", me_exp, exp_d);
        check_eq("stall_mod", me_mod, cur_n);
        stall_left--;
        if (stall_left == 0) stall_on = 1'b0;
      end else if (me_req) begin
        me_rdy = 1'b1;
        pres   = modexp(me_base, me_exp, me_mod);
        pend   = 1'b1;
        pcnt   = eng_hold ? 1000 : $urandom_range(0, 3);
        if (me_exp != 64'd2) begin
          if (xcnt == 0) first_x_exp = me_exp;
          if (xcnt < NB) check_eq("x_base", me_base, tb_base(xcnt));
          else check_eq("extra_witness", xcnt, NB - 1);
          check_eq("x_exp", me_exp, exp_d);
          check_eq("x_mod", me_mod, cur_n);
          xcnt++;
        end else begin
          check_eq("sq_mod", me_mod, cur_n);
        end
      end
    end
  end

  // Output monitor: request rise time and scoreboard pop on done.
  initial begin
    bit ep;
    int ec;
    forever begin
      @(negedge clk);
      if (me_req && req_rise < 0) req_rise = cyc - start_cyc + 1;
      if (done) begin
        done_cnt++;
        if (sb_p.size() == 0) begin
          check_eq("unexpected_done", 64'd1, 64'd0);
        end else begin
          ep = sb_p.pop_front();
          ec = sb_c.pop_front();
          check_eq("is_prime", {63'd0, is_prime}, {63'd0, ep});
          check_eq("busy_at_done", {63'd0, busy}, 64'd0);
          if (ec >= 0) check_eq("done_cycle", cyc - start_cyc + 1, ec);
        end
      end
    end
  end

  // exp_req: -1 = request must never rise, -2 = don't care, else rise cycle.
  task automatic run(input logic [63:0] nv, input bit exp_p, input int exp_done, input int exp_req);
    int t0;
    int g;
    cur_n = nv;
    exp_d = nv - 64'd1;
    if (nv > 64'd3 && nv[0]) while (!exp_d[0]) exp_d = exp_d >> 1;
    xcnt = 0;
    req_rise = -1;
    t0 = done_cnt;
    sb_p.push_back(exp_p);
    sb_c.push_back(exp_done);
    start = 1'b1;
    n = nv;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    check_eq("busy_c1", {63'd0, busy}, 64'd1);
    g = 0;
    while (done_cnt == t0 && g < 20000) begin
      @(posedge clk); g++;
    end
    #1;
    if (done_cnt == t0) begin
      check_eq("done_timeout", 64'd0, 64'd1);
      void'(sb_p.pop_back());
      void'(sb_c.pop_back());
    end
    if (exp_req != -2) check_eq("req_rise", req_rise, exp_req);
  endtask

  initial begin
    int g;
    int dc;
    rst = 1'b0;
    start = 1'b0;
    n = 64'd0;
    #2;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_prime", {63'd0, is_prime}, 64'd0);
    check_eq("rst_req", {63'd0, me_req}, 64'd0);
    check_eq("rst_base", me_base, 64'd0);
    check_eq("rst_exp", me_exp, 64'd0);
    check_eq("rst_mod", me_mod, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // trivial cases
    run(64'd0, 1'b0, 2, -1);
    run(64'd1, 1'b0, 2, -1);
    run(64'd4, 1'b0, 2, -1);
    run(64'd2, 1'b1, 2, -1);
    run(64'd3, 1'b1, 2, -1);

    // Carmichael 561: d=35, s=4 -> first request at cycle 2+s
    run(64'd561, 1'b0, -1, 6);
    check_eq("d_561", first_x_exp, 64'd35);

    // largest 64-bit prime: every witness issued once
    run(BIG_P, 1'b1, -1, -2);
    check_eq("big_p_witnesses", xcnt, NB);

    // strong pseudoprime to 2,3,5,7
    run(64'd3215031751, 1'b0, -1, -2);
`ifndef MR_FAST_WITNESS_EN
    check_eq("spsp_caught_at_11", xcnt, 5);
`endif

    // n=13 with engine stalled 5 cycles on the first request
    stall_left = 5;
    run(64'd13, 1'b1, -1, -2);
    check_eq("n13_witnesses", xcnt, NB);
    check_eq("stall_consumed", stall_left, 0);

    // more patterns
    run(64'd91, 1'b0, -1, -2);
    run(64'd9, 1'b0, -1, -2);
    run(64'd2305843009213693951, 1'b1, -1, -2);

    // reset while waiting for the engine, then a late result strobe
    eng_hold = 1'b1;
    cur_n = BIG_P;
    exp_d = BIG_P - 64'd1;
    while (!exp_d[0]) exp_d = exp_d >> 1;
    xcnt = 0;
    start = 1'b1;
    n = BIG_P;
    @(posedge clk); #1;
    start = 1'b0;
    g = 0;
    while (xcnt == 0 && g < 100) begin
      @(posedge clk); #2; g++;
    end
    if (xcnt == 0) check_eq("reach_wait_x_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    check_eq("wx_busy", {63'd0, busy}, 64'd1);
    check_eq("wx_req_dropped", {63'd0, me_req}, 64'd0);
    dc = done_cnt;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_busy", {63'd0, busy}, 64'd0);
    check_eq("mid_rst_req", {63'd0, me_req}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    eng_hold = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    inj_val = BIG_P - 64'd1;
    inject = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("late_vld_no_done", done_cnt, dc);
    check_eq("late_vld_busy", {63'd0, busy}, 64'd0);
    check_eq("late_vld_req", {63'd0, me_req}, 64'd0);
    run(64'd7, 1'b1, -1, -2);

    check_eq("sb_empty", sb_p.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
